// File: rtl/byte_serial_adder.sv
// Byte-serial adder: adds two NUM_BYTES-wide operands one byte pair per accepted beat, LSB first.
// Optional two's-complement overflow flag output enabled by defining BYTE_SERIAL_ADDER_OVF_EN.
module byte_serial_adder #(
  parameter int NUM_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       carry_in,
  input  logic [7:0] first_byte,
  input  logic [7:0] second_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] sum_bytes,
  output logic       sum_valid,
  output logic [3:0] sum_index,
  output logic       carry_out,
  output logic       done
`ifdef BYTE_SERIAL_ADDER_OVF_EN
  ,
  output logic       ovf_flag
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       carry_q, carry_d;
  logic [7:0] sum_q, sum_d;
  logic       sum_valid_q, sum_valid_d;
  logic [3:0] sum_index_q, sum_index_d;
  logic       carry_out_q, carry_out_d;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
  logic       ovf_q, ovf_d;
  logic       carry_into_msb;
`endif

  logic [8:0] add_res;

  assign add_res = {1'b0, first_byte} + {1'b0, second_byte} + {8'b0, carry_q};

`ifdef BYTE_SERIAL_ADDER_OVF_EN
  // Carry into bit 7 recovered from the sum bit and the two operand bits.
  assign carry_into_msb = first_byte[7] ^ second_byte[7] ^ add_res[7];
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    sum_index_d = sum_index_q;
    carry_out_d = carry_out_q;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          cnt_d       = '0;
          carry_d     = carry_in;
          carry_out_d = 1'b0;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
          ovf_d       = 1'b0;
`endif
        end
      end
      RUN: begin
        if (in_valid) begin
          sum_d       = add_res[7:0];
          sum_valid_d = 1'b1;
          sum_index_d = cnt_q;
          carry_d     = add_res[8];
          if (cnt_q == LAST_IDX) begin
            state_d     = DONE;
            carry_out_d = add_res[8];
`ifdef BYTE_SERIAL_ADDER_OVF_EN
            ovf_d       = carry_into_msb ^ add_res[8];
`endif
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= 8'h00;
      sum_valid_q <= 1'b0;
      sum_index_q <= '0;
      carry_out_q <= 1'b0;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      sum_index_q <= sum_index_d;
      carry_out_q <= carry_out_d;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // The last sum beat is emitted during the single DONE cycle, so done aligns with it.
  assign in_ready  = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum_bytes = sum_q;
  assign sum_valid = sum_valid_q;
  assign sum_index = sum_index_q;
  assign carry_out = carry_out_q;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
  assign ovf_flag  = ovf_q;
`endif

endmodule

// File: tb/tb_byte_serial_adder.sv
// Self-checking bench for byte_serial_adder: directed cases plus randomized operands
// compared against whole-operand integer arithmetic.
module tb_byte_serial_adder;

  localparam int NB = 4;
  localparam int W  = NB * 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       carry_in;
  logic [7:0] first_byte;
  logic [7:0] second_byte;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] sum_bytes;
  logic       sum_valid;
  logic [3:0] sum_index;
  logic       carry_out;
  logic       done;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
  logic       ovf_flag;
`endif

  byte_serial_adder #(.NUM_BYTES(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .carry_in   (carry_in),
    .first_byte (first_byte),
    .second_byte(second_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum_bytes  (sum_bytes),
    .sum_valid  (sum_valid),
    .sum_index  (sum_index),
    .carry_out  (carry_out),
    .done       (done)
`ifdef BYTE_SERIAL_ADDER_OVF_EN
    ,
    .ovf_flag   (ovf_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Output monitor state, sampled on the falling edge.
  logic [3:0] got_idx[$];
  logic [7:0] got_byte[$];
  int         done_cnt = 0;
  int         spurious = 0;
  logic       done_carry;
  logic       done_on_last;
  logic       done_ovf;
  logic       acc_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_prev = 1'b0;
    end else begin
      if (sum_valid !== acc_prev) spurious++;
      if (sum_valid) begin
        got_idx.push_back(sum_index);
        got_byte.push_back(sum_bytes);
      end
      if (done) begin
        done_cnt++;
        done_carry   = carry_out;
        done_on_last = sum_valid && (sum_index == 4'(NB - 1));
`ifdef BYTE_SERIAL_ADDER_OVF_EN
        done_ovf     = ovf_flag;
`else
        done_ovf     = 1'b0;
`endif
      end
      acc_prev = in_valid && in_ready;
    end
  end

  // Drives one complete addition and checks all of its observable results.
  task automatic test_operation(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input int gap, input bit poke_start);
    logic [W:0] full;
    logic       exp_ovf;
    int         waited;
    full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    exp_ovf = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    got_idx.delete();
    got_byte.delete();
    done_cnt = 0;
    spurious = 0;

    @(posedge clk); #1;
    start    = 1'b1;
    carry_in = cin;
    @(posedge clk); #1;
    start    = 1'b0;
    carry_in = 1'($urandom);
    checks++;
    if (carry_out !== 1'b0) begin
      errors++;
      $display("FAIL %s carry_out_clear_on_start: got %b expected 0", name, carry_out);
    end

    for (int i = 0; i < NB; i++) begin
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        first_byte  = 8'($urandom);
        second_byte = 8'($urandom);
        start       = poke_start;
        @(posedge clk); #1;
        start = 1'b0;
      end
      waited = 0;
      while (!in_ready && waited < 20) begin
        @(posedge clk); #1;
        waited++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s in_ready_timeout pair %0d: got %b expected 1", name, i, in_ready);
        in_valid = 1'b0;
        return;
      end
      in_valid    = 1'b1;
      first_byte  = a[8*i +: 8];
      second_byte = b[8*i +: 8];
      start       = poke_start && (i == 1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid    = 1'b0;
    first_byte  = 8'($urandom);
    second_byte = 8'($urandom);
    repeat (4) @(posedge clk);
    #1;

    checks++;
    if (got_byte.size() != NB) begin
      errors++;
      $display("FAIL %s sum_valid_count: got %0d expected %0d", name, got_byte.size(), NB);
    end else begin
      for (int i = 0; i < NB; i++) begin
        checks++;
        if (got_idx[i] !== 4'(i) || got_byte[i] !== full[8*i +: 8]) begin
          errors++;
          $display("FAIL %s sum_beat %0d: got idx %0d byte %h expected idx %0d byte %h",
                   name, i, got_idx[i], got_byte[i], i, full[8*i +: 8]);
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
    end else begin
      checks++;
      if (done_carry !== full[W] || done_on_last !== 1'b1) begin
        errors++;
        $display("FAIL %s done_beat: got carry %b on_last %b expected carry %b on_last 1",
                 name, done_carry, done_on_last, full[W]);
      end
`ifdef BYTE_SERIAL_ADDER_OVF_EN
      checks++;
      if (done_ovf !== exp_ovf) begin
        errors++;
        $display("FAIL %s ovf_at_done: got %b expected %b", name, done_ovf, exp_ovf);
      end
`endif
    end
    checks++;
    if (carry_out !== full[W] || in_ready !== 1'b0 || spurious != 0) begin
      errors++;
      $display("FAIL %s hold_after_done: got carry %b ready %b spurious %0d expected carry %b ready 0 spurious 0",
               name, carry_out, in_ready, spurious, full[W]);
    end
`ifdef BYTE_SERIAL_ADDER_OVF_EN
    checks++;
    if (ovf_flag !== exp_ovf) begin
      errors++;
      $display("FAIL %s ovf_hold: got %b expected %b", name, ovf_flag, exp_ovf);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || sum_bytes !== 8'h00 || sum_valid !== 1'b0 ||
        sum_index !== 4'd0 || carry_out !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got ready %b sum %h valid %b idx %0d cout %b done %b expected all zero",
               in_ready, sum_bytes, sum_valid, sum_index, carry_out, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got ready %b done %b expected 0 0", in_ready, done);
    end
  endtask

  task automatic test_directed();
    test_operation("inc_ff", W'(32'h0000_00FF), W'(32'h0000_0001), 1'b0, 0, 1'b0);
    test_operation("wrap_all", W'(32'hFFFF_FFFF), W'(32'h0000_0001), 1'b0, 0, 1'b0);
    test_operation("ovf_cin", W'(32'h7FFF_FFFF), W'(32'h0000_0000), 1'b1, 0, 1'b0);
  endtask

  task automatic test_stall();
    test_operation("stall3", W'(32'h0000_00FF), W'(32'h0000_0001), 1'b0, 3, 1'b0);
  endtask

  task automatic test_start_in_run();
    test_operation("start_in_run", W'(32'h0000_0080), W'(32'h0000_0080), 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_op();
    @(posedge clk); #1;
    start    = 1'b1;
    carry_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid    = 1'b1;
      first_byte  = 8'hFF;
      second_byte = 8'hFF;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || sum_bytes !== 8'h00 || sum_valid !== 1'b0 ||
        sum_index !== 4'd0 || carry_out !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_values: got ready %b sum %h valid %b idx %0d cout %b done %b expected all zero",
               in_ready, sum_bytes, sum_valid, sum_index, carry_out, done);
    end
    done_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 0 || carry_out !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_abort: got done_cnt %0d cout %b ready %b expected 0 0 0",
               done_cnt, carry_out, in_ready);
    end
    test_operation("after_reset", W'(32'h0101_0101), W'(32'h0101_0101), 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int n = 0; n < 25; n++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (n % 5 == 0) b = ~a;
      test_operation($sformatf("rand%0d", n), a, b, 1'($urandom),
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    carry_in    = 1'b0;
    first_byte  = 8'h00;
    second_byte = 8'h00;
    in_valid    = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_start_in_run();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
